execute_alu: RTL and testbench
==============================

EXECUTE_ALU -- requirements
Module: execute

Interface
REQ-001 The block SHALL have no parameters; all datapath widths SHALL be fixed at 64 bits (RV64 integer ALU).
REQ-002 clk  input  1  single clock; all sequential state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 opr_a_i  input  64  operand A (rs1 or PC).
REQ-005 opr_b_i  input  64  operand B (rs2 or immediate); bits [5:0] also give the shift amount.
REQ-006 alu_func_i  input  4  operation select (encoding in REQ-011).
REQ-007 alu_res_o  output  64  combinational ALU result for the current inputs.
REQ-008 alu_zero_o  output  1  combinational; 1 when alu_res_o == 0.
REQ-009 alu_res_q_o  output  64  alu_res_o registered on each rising clk edge.

Function
REQ-010 alu_res_o and alu_zero_o SHALL be purely combinational from opr_a_i, opr_b_i and alu_func_i, with zero cycle latency and no dependence on clk or reset.
REQ-011 alu_func_i encoding and the resulting alu_res_o SHALL be:
- 0000 ADD: a+b mod 2^64, carry discarded.
- 0001 SUB: a-b mod 2^64, borrow discarded.
- 0010 SLL: a << b[5:0], zero fill.
- 0011 SRL: a >> b[5:0], zero fill.
- 0100 SRA: a >> b[5:0], sign fill from a[63].
- 0101 OR: a | b.
- 0110 AND: a & b.
- 0111 XOR: a ^ b.
- 1000 SLTU: 1 if a < b unsigned, else 0.
- 1001 SLT: 1 if a < b signed two's complement, else 0.
REQ-012 For SLT and SLTU the result SHALL be zero-extended to 64 bits (bits [63:1] = 0).
REQ-013 Shifts SHALL use only opr_b_i[5:0]; opr_b_i[63:6] SHALL be ignored.
REQ-014 A shift amount of 0 SHALL return opr_a_i unchanged for SLL, SRL and SRA.
REQ-015 Overflow SHALL NOT be flagged or trapped; ADD/SUB SHALL wrap.
REQ-016 Unused codes 1010-1111 SHALL give alu_res_o = 0 (and therefore alu_zero_o = 1).
REQ-017 When a == b, SLT and SLTU SHALL both return 0.
REQ-018 The output SHALL contain no X/Z for any fully known input combination, including unused codes.
REQ-019 alu_res_q_o SHALL equal the alu_res_o value sampled at the previous rising clk edge (1-cycle latency); there is no enable.

Reset
REQ-020 When reset is high at a rising clk edge, alu_res_q_o SHALL become 0 after that edge.
REQ-021 Reset SHALL take priority over capturing alu_res_o at the same edge.
REQ-022 Reset SHALL NOT affect alu_res_o or alu_zero_o.
REQ-023 alu_res_q_o SHALL resume capturing on the first rising edge with reset low.

Verification
REQ-024 SUB, a=0, b=1 -> alu_res_o=FFFF_FFFF_FFFF_FFFF, alu_zero_o=0; ADD, a=FFFF_FFFF_FFFF_FFFF, b=1 -> 0, alu_zero_o=1.
REQ-025 Shifts:
- SLL a=1, b=0x3F -> 8000_0000_0000_0000.
- SLL a=1, b=0x43 -> 0x8 (only b[5:0] used).
- SRL a=8000_0000_0000_0000, b=0x3F -> 1.
- SRA, same operands -> FFFF_FFFF_FFFF_FFFF.
- SRA a=FFFF_FFFF_FFFF_F000, b=5 -> FFFF_FFFF_FFFF_FF80.
REQ-026 Compares, a=FFFF_FFFF_FFFF_FFFF, b=1 -> SLT=1, SLTU=0; with a=b=0x1234 -> both 0.
REQ-027 Logic:
- OR a=FFFF_0000_FFFF_0000, b=0000_FFFF_0000_FFFF -> all ones.
- AND, same operands -> 0.
- XOR a=all ones, b=0F0F_0F0F_0F0F_0F0F -> F0F0_F0F0_F0F0_F0F0.
REQ-028 alu_func_i=1010 with any operands -> alu_res_o=0, alu_zero_o=1.
REQ-029 Register and reset:
- Drive ADD 2+3 and clock once -> alu_res_q_o=5.
- Assert reset and clock once -> alu_res_q_o=0 while alu_res_o stays 5.
- Release reset and clock once -> alu_res_q_o=5.

Source files
------------

// File: rtl/execute_alu.sv
// RV64 integer execute-stage ALU: combinational result and zero flag,
// plus a copy of the result registered once per clock.
module execute_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] opr_a_i,
    input  logic [63:0] opr_b_i,
    input  logic [3:0]  alu_func_i,
    output logic [63:0] alu_res_o,
    output logic        alu_zero_o,
    output logic [63:0] alu_res_q_o
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLL  = 4'b0010,
        OP_SRL  = 4'b0011,
        OP_SRA  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_AND  = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SLT  = 4'b1001
    } alu_op_e;

    alu_op_e     w_op;
    logic [5:0]  w_shamt;
    logic [63:0] w_sra;
    logic        w_lt_u;
    logic        w_lt_s;
    logic [63:0] w_res;
    logic [63:0] r_res_q;

    // Only the low six bits of operand B act as the shift amount.
    assign w_op    = alu_op_e'(alu_func_i);
    assign w_shamt = opr_b_i[5:0];
    assign w_sra   = $signed(opr_a_i) >>> w_shamt;
    assign w_lt_u  = opr_a_i < opr_b_i;
    assign w_lt_s  = $signed(opr_a_i) < $signed(opr_b_i);

    // Select the operation result; unused codes fall through to zero.
    always_comb begin
        // NOTE: default assigned first so every path drives w_res and no latch is inferred.
        w_res = '0;
        case (w_op)
            OP_ADD:  w_res = opr_a_i + opr_b_i;
            OP_SUB:  w_res = opr_a_i - opr_b_i;
            OP_SLL:  w_res = opr_a_i << w_shamt;
            OP_SRL:  w_res = opr_a_i >> w_shamt;
            OP_SRA:  w_res = w_sra;
            OP_OR:   w_res = opr_a_i | opr_b_i;
            OP_AND:  w_res = opr_a_i & opr_b_i;
            OP_XOR:  w_res = opr_a_i ^ opr_b_i;
            OP_SLTU: w_res = {63'b0, w_lt_u};
            OP_SLT:  w_res = {63'b0, w_lt_s};
            default: w_res = '0;
        endcase
    end

    assign alu_res_o  = w_res;
    assign alu_zero_o = (w_res == 64'd0);

    // Register the result every cycle; reset wins over capture.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps the register update race-free against other clocked logic.
        if (reset) begin
            r_res_q <= '0;
        end else begin
            r_res_q <= w_res;
        end
    end

    assign alu_res_q_o = r_res_q;

endmodule

// File: tb/tb_execute_alu.sv
// Scoreboard bench for execute_alu: a driver issues one operation per cycle
// and queues the expected response; a monitor checks after each rising edge.
module tb_execute_alu;

    logic        clk;
    logic        reset;
    logic [63:0] opr_a_i;
    logic [63:0] opr_b_i;
    logic [3:0]  alu_func_i;
    logic [63:0] alu_res_o;
    logic        alu_zero_o;
    logic [63:0] alu_res_q_o;

    execute_alu dut (
        .clk         (clk),
        .reset       (reset),
        .opr_a_i     (opr_a_i),
        .opr_b_i     (opr_b_i),
        .alu_func_i  (alu_func_i),
        .alu_res_o   (alu_res_o),
        .alu_zero_o  (alu_zero_o),
        .alu_res_q_o (alu_res_q_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        zero;
        logic [63:0] res_q;
    } item_t;

    item_t q[$];
    int total = 0;
    int bad   = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference behaviour written from the operation definitions.
    function automatic logic [63:0] model(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        int unsigned sh;
        sh = int'(b[5:0]);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return a >> sh;
            4'd4: return a[63] ? ~((~a) >> sh) : (a >> sh);
            4'd5: return a | b;
            4'd6: return a & b;
            4'd7: return a ^ b;
            4'd8: return (a < b) ? 64'd1 : 64'd0;
            4'd9: return ((a ^ MSB) < (b ^ MSB)) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic issue(input string name, input logic [3:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic rst);
        item_t it;
        @(negedge clk);
        alu_func_i = f;
        opr_a_i    = a;
        opr_b_i    = b;
        reset      = rst;
        it.name  = name;
        it.res   = model(f, a, b);
        it.zero  = (it.res == 64'd0);
        it.res_q = rst ? 64'd0 : it.res;
        q.push_back(it);
    endtask

    // Monitor: after each rising edge, the registered output reflects the
    // operation presented before that edge, and the combinational outputs
    // still show it because inputs only change on the falling edge.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                check({it.name, ".res"},   alu_res_o,          it.res);
                check({it.name, ".zero"},  {63'b0, alu_zero_o}, {63'b0, it.zero});
                check({it.name, ".res_q"}, alu_res_q_o,        it.res_q);
            end
        end
    end

    initial begin
        int unsigned f;
        logic [63:0] a;
        logic [63:0] b;
        logic        rst;
        int          waited;

        reset      = 1'b1;
        opr_a_i    = '0;
        opr_b_i    = '0;
        alu_func_i = '0;

        issue("reset_state", 4'd0, 64'd7, 64'd9, 1'b1);
        issue("sub_0_1",     4'd1, 64'd0, 64'd1, 1'b0);
        issue("add_wrap",    4'd0, ONES, 64'd1, 1'b0);
        issue("sll_63",      4'd2, 64'd1, 64'h3F, 1'b0);
        issue("sll_b43",     4'd2, 64'd1, 64'h43, 1'b0);
        issue("srl_63",      4'd3, MSB, 64'h3F, 1'b0);
        issue("sra_63",      4'd4, MSB, 64'h3F, 1'b0);
        issue("sra_5",       4'd4, 64'hFFFF_FFFF_FFFF_F000, 64'd5, 1'b0);
        issue("sll_0",       4'd2, 64'hDEAD_BEEF_0123_4567, 64'h40, 1'b0);
        issue("sra_0",       4'd4, 64'hF000_0000_0000_0001, 64'd0, 1'b0);
        issue("slt_neg",     4'd9, ONES, 64'd1, 1'b0);
        issue("sltu_big",    4'd8, ONES, 64'd1, 1'b0);
        issue("slt_eq",      4'd9, 64'h1234, 64'h1234, 1'b0);
        issue("sltu_eq",     4'd8, 64'h1234, 64'h1234, 1'b0);
        issue("or_mix",      4'd5, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0);
        issue("and_mix",     4'd6, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0);
        issue("xor_mix",     4'd7, ONES, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        issue("unused_a",    4'hA, 64'h1234_5678, 64'h9ABC, 1'b0);
        issue("unused_f",    4'hF, ONES, ONES, 1'b0);
        issue("reg_add",     4'd0, 64'd2, 64'd3, 1'b0);
        issue("reg_reset",   4'd0, 64'd2, 64'd3, 1'b1);
        issue("reg_resume",  4'd0, 64'd2, 64'd3, 1'b0);

        for (int i = 0; i < 400; i++) begin
            f   = $urandom_range(0, 15);
            a   = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 64'($urandom_range(0, 127));
                2:       b = a ^ (64'd1 << $urandom_range(0, 63));
                default: b = {$urandom(), $urandom()};
            endcase
            if ($urandom_range(0, 3) == 0) a[63] = ~a[63];
            rst = ($urandom_range(0, 15) == 0);
            issue($sformatf("rand%0d_f%0d", i, f), 4'(f), a, b, rst);
        end

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending expected=0 pending", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
